mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 27, memory byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 4096, maximum WAIT cycles before abort (>=2).
REQ-004 Port clk  in  1  sole clock; one clock domain, the CPU clock.
REQ-005 Port rst  in  1  reset; synchronous, active-high.
REQ-006 Port i_req  in  1  instruction-port request, level, held until i_ack.
REQ-007 Port i_addr  in  ADDR_W  instruction read address.
REQ-008 Port i_ack  out  1  one-cycle pulse, instruction transaction complete.
REQ-009 Port i_rdata  out  DATA_W  instruction read data, valid with i_ack.
REQ-010 Port d_req  in  1  data-port request, level, held until d_ack.
REQ-011 Port d_we  in  1  data-port direction: 1 = write, 0 = read.
REQ-012 Port d_addr  in  ADDR_W  data address.
REQ-013 Port d_wdata  in  DATA_W  data write value.
REQ-014 Port d_ack  out  1  one-cycle pulse, data transaction complete.
REQ-015 Port d_rdata  out  DATA_W  data read value, valid with d_ack.
REQ-016 Port mem_addr  out  ADDR_W  address to the shared memory subsystem.
REQ-017 Port mem_write_data  out  DATA_W  write data to the memory subsystem.
REQ-018 Port mem_read_or_write  out  1  direction to memory: 1 = read, 0 = write.
REQ-019 Port mem_sig  out  1  one-cycle launch strobe to the memory subsystem.
REQ-020 Port mem_read_data  in  DATA_W  read data from memory, valid with mem_finish.
REQ-021 Port mem_finish  in  1  one-cycle completion pulse from memory.
REQ-022 Port busy  out  1  high in every state except IDLE.
REQ-023 Port grant_id  out  1  owner of the current transaction: 0 = instruction, 1 = data.
REQ-024 Port timeout_err  out  1  sticky flag; set on watchdog abort.

Function
REQ-025 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with one state per cycle except WAIT.
REQ-026 In IDLE with at least one req high, the block SHALL register the winner's addr, wdata, direction and grant_id, then go to ISSUE.
REQ-027 Arbitration SHALL be round-robin. When both reqs are high, the port not granted last wins. After reset, the data port wins the first tie.
REQ-028 The instruction port SHALL always issue reads: mem_read_or_write = 1.
REQ-029 In ISSUE, mem_sig SHALL be 1 for exactly one cycle with the registered mem_addr, mem_write_data and mem_read_or_write; the FSM then goes to WAIT.
REQ-030 mem_addr, mem_write_data and mem_read_or_write SHALL hold stable from ISSUE until the next grant.
REQ-031 In WAIT, mem_finish = 1 SHALL capture mem_read_data into the owner's rdata register and move the FSM to RESP.
REQ-032 mem_finish SHALL be ignored in IDLE, ISSUE and RESP.
REQ-033 In RESP, the owner's ack SHALL be 1 for one cycle; the FSM then goes to IDLE. Both acks SHALL never be high in the same cycle.
REQ-034 Latency SHALL be as follows: req sampled in IDLE at cycle n gives mem_sig at n+1; mem_finish at cycle m gives ack at m+1; a new grant is possible at m+2.
REQ-035 On a write, rdata SHALL still be loaded from mem_read_data; requesters ignore it.
REQ-036 i_rdata and d_rdata SHALL hold their value until that port's next ack.
REQ-037 If the owner drops req after grant, the transaction SHALL still complete and the ack SHALL still pulse.
REQ-038 A watchdog SHALL count WAIT cycles from 0. If the count reaches TIMEOUT-1 without mem_finish, then:
- timeout_err is set;
- the owner's rdata is loaded with 0;
- the FSM goes to RESP and the ack pulses normally.
REQ-039 mem_finish arriving in the same cycle as the timeout limit SHALL take priority: normal capture, timeout_err unchanged.
REQ-040 timeout_err SHALL clear only on rst.

Reset
REQ-041 While rst = 1, the outputs SHALL be: state = IDLE, mem_sig = 0, i_ack = 0, d_ack = 0, busy = 0, grant_id = 0, timeout_err = 0, mem_addr = 0, mem_write_data = 0, mem_read_or_write = 1, i_rdata = 0, d_rdata = 0, watchdog = 0, round-robin pointer = instruction-last.
REQ-042 Reset asserted mid-transaction SHALL abandon it: no ack is issued, and a mem_finish arriving later SHALL be ignored.

Structure
REQ-043 The shared package mem_arb_pkg SHALL hold:
- the state enum (IDLE, ISSUE, WAIT, RESP);
- the port-id constants PORT_I = 0 and PORT_D = 1;
- the direction constants MEM_READ = 1 and MEM_WRITE = 0.
REQ-044 The watchdog counter SHALL be the single sub-module mem_arb_watchdog, with ports clk, rst, enable, expired and parameter TIMEOUT. Arbitration and FSM logic SHALL stay in mem_arbiter.

Verification
REQ-045 Scenario: i_req, i_addr = 0x0000100; mem_finish 5 cycles after mem_sig with data 0xDEADBEEF -> mem_read_or_write = 1; i_ack one cycle after finish; i_rdata = 0xDEADBEEF.
REQ-046 Scenario: d_req, d_we = 1, d_addr = 0x0000200, d_wdata = 0x12345678 -> mem_read_or_write = 0; mem_write_data = 0x12345678; d_ack only; i_ack stays 0.
REQ-047 Scenario: i_req and d_req both held high for 4 transactions after reset -> grants alternate D, I, D, I; acks are never simultaneous.
REQ-048 Scenario: TIMEOUT = 8 with mem_finish never asserted -> after 8 WAIT cycles: timeout_err = 1, ack pulses, rdata = 0; a following request still completes.
REQ-049 Scenario: rst asserted in WAIT, then mem_finish pulses 2 cycles later -> no ack, busy = 0; the next request gives mem_sig at n+1.
REQ-050 Scenario: mem_finish pulse in IDLE and in ISSUE -> ignored; the transaction completes only on the later finish in WAIT.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
//
// Contents:
//   state_t    arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   PORT_I/D   grant identifiers for the instruction and data ports
//   MEM_READ/WRITE  encoding of mem_read_or_write
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - WAIT-state cycle counter that flags a stuck memory transaction
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   enable   in   high while the arbiter sits in WAIT; low clears the count
//   expired  out  high in the WAIT cycle whose index is TIMEOUT-1
module mem_arb_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // The first WAIT cycle sees count 0; the count saturates at LIMIT so it
    // can never wrap even if the FSM were held in WAIT past expiry.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between instruction and data requesters
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             instruction read request (level, held until i_ack)
//   i_ack/i_rdata            instruction completion pulse and read data
//   d_req/d_we/d_addr/d_wdata  data request (level, held until d_ack)
//   d_ack/d_rdata            data completion pulse and read data
//   mem_addr/mem_write_data/mem_read_or_write  registered command to memory
//   mem_sig                  one-cycle launch strobe
//   mem_read_data/mem_finish memory completion and read data
//   busy                     high whenever the FSM is not in IDLE
//   grant_id                 owner of the current/last transaction
//   timeout_err              sticky watchdog-abort flag
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read_or_write,
    output logic              mem_sig,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_finish,

    output logic              busy,
    output logic              grant_id,
    output logic              timeout_err
);

    state_t state;
    state_t state_next;

    logic   winner;
    logic   any_req;
    logic   wd_expired;

    assign any_req = i_req || d_req;

    // grant_id doubles as the round-robin pointer: it always names the port
    // granted last, and it resets to PORT_I so the data port wins the first tie.
    always_comb begin
        winner = PORT_I;
        if (i_req && d_req) begin
            winner = (grant_id == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            winner = PORT_D;
        end
    end

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .enable  (state == WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are decoded from the state but masked by rst so that they are
    // quiet for the whole reset window, including the cycle before the state
    // register has been forced back to IDLE.
    always_comb begin
        state_next = state;
        mem_sig    = 1'b0;
        busy       = 1'b0;
        i_ack      = 1'b0;
        d_ack      = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_sig    = !rst;
                busy       = !rst;
                state_next = WAIT;
            end
            WAIT: begin
                busy = !rst;
                if (mem_finish || wd_expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                busy       = !rst;
                i_ack      = !rst && (grant_id == PORT_I);
                d_ack      = !rst && (grant_id == PORT_D);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command registers change only on a grant, so they stay stable through
    // ISSUE, WAIT and RESP and on into the following IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id          <= PORT_I;
            mem_addr          <= '0;
            mem_write_data    <= '0;
            mem_read_or_write <= MEM_READ;
        end else if (state == IDLE && any_req) begin
            grant_id <= winner;
            if (winner == PORT_D) begin
                mem_addr          <= d_addr;
                mem_write_data    <= d_wdata;
                mem_read_or_write <= d_we ? MEM_WRITE : MEM_READ;
            end else begin
                mem_addr          <= i_addr;
                mem_write_data    <= '0;
                mem_read_or_write <= MEM_READ;
            end
        end
    end

    // Response capture. A finish in the expiry cycle wins over the abort, so
    // the abort path only fires when mem_finish is low. Writes load rdata too;
    // the requester simply ignores it.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata     <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else if (state == WAIT) begin
            if (mem_finish) begin
                if (grant_id == PORT_D) begin
                    d_rdata <= mem_read_data;
                end else begin
                    i_rdata <= mem_read_data;
                end
            end else if (wd_expired) begin
                timeout_err <= 1'b1;
                if (grant_id == PORT_D) begin
                    d_rdata <= '0;
                end else begin
                    i_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read_or_write;
    logic              mem_sig;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_finish;
    logic              busy;
    logic              grant_id;
    logic              timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_req             (i_req),
        .i_addr            (i_addr),
        .i_ack             (i_ack),
        .i_rdata           (i_rdata),
        .d_req             (d_req),
        .d_we              (d_we),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_ack             (d_ack),
        .d_rdata           (d_rdata),
        .mem_addr          (mem_addr),
        .mem_write_data    (mem_write_data),
        .mem_read_or_write (mem_read_or_write),
        .mem_sig           (mem_sig),
        .mem_read_data     (mem_read_data),
        .mem_finish        (mem_finish),
        .busy              (busy),
        .grant_id          (grant_id),
        .timeout_err       (timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model: pending requests per port, who was granted
    // last, and what each port's rdata and the error flag should read.
    bit                pi_pend;
    bit                pd_pend;
    bit                pd_we_m;
    logic [ADDR_W-1:0] pi_addr_m;
    logic [ADDR_W-1:0] pd_addr_m;
    logic [DATA_W-1:0] pd_wdata_m;
    bit                last_owner;
    logic [DATA_W-1:0] exp_irdata;
    logic [DATA_W-1:0] exp_drdata;
    bit                exp_terr;
    bit                seen_grant;

    task automatic model_reset();
        pi_pend    = 1'b0;
        pd_pend    = 1'b0;
        last_owner = 1'b0;
        exp_irdata = '0;
        exp_drdata = '0;
        exp_terr   = 1'b0;
    endtask

    task automatic drive_reqs();
        i_req   = pi_pend;
        i_addr  = pi_addr_m;
        d_req   = pd_pend;
        d_we    = pd_we_m;
        d_addr  = pd_addr_m;
        d_wdata = pd_wdata_m;
    endtask

    task automatic new_i(input logic [ADDR_W-1:0] a);
        pi_pend   = 1'b1;
        pi_addr_m = a;
    endtask

    task automatic new_d(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        pd_pend    = 1'b1;
        pd_we_m    = we;
        pd_addr_m  = a;
        pd_wdata_m = wd;
    endtask

    // Called at a negedge in IDLE with requests already driven. fin_at is the
    // WAIT-cycle index of mem_finish; a negative value means memory never answers.
    task automatic serve(input int fin_at, input logic [DATA_W-1:0] fdata, input bit spur, input bit drop);
        bit                win;
        bit                dir;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] rd;
        int                nwait;

        if (pi_pend && pd_pend) win = (last_owner == 1'b0);
        else                    win = pd_pend;
        ea  = win ? pd_addr_m : pi_addr_m;
        dir = win ? !pd_we_m : 1'b1;
        rd  = '0;

        if (spur) begin
            mem_finish    = 1'b1;
            mem_read_data = DATA_W'($urandom);
        end

        @(negedge clk);
        mem_finish = 1'b0;
        check("issue.mem_sig", mem_sig, 1);
        check("issue.busy", busy, 1);
        check("issue.grant_id", grant_id, win);
        check("issue.mem_addr", mem_addr, ea);
        check("issue.dir", mem_read_or_write, dir);
        check("issue.acks", {i_ack, d_ack}, 0);
        if (win && pd_we_m) check("issue.wdata", mem_write_data, pd_wdata_m);
        seen_grant = grant_id;

        if (spur) begin
            mem_finish    = 1'b1;
            mem_read_data = DATA_W'($urandom);
        end
        if (drop) begin
            if (win) pd_pend = 1'b0;
            else     pi_pend = 1'b0;
            drive_reqs();
        end

        nwait = (fin_at < 0) ? TIMEOUT : fin_at + 1;
        for (int k = 0; k < nwait; k++) begin
            @(negedge clk);
            mem_finish = 1'b0;
            check("wait.strobes", {mem_sig, i_ack, d_ack}, 0);
            check("wait.mem_addr", mem_addr, ea);
            if (k == fin_at) begin
                rd            = fdata;
                mem_finish    = 1'b1;
                mem_read_data = rd;
            end
        end

        if (fin_at < 0) exp_terr = 1'b1;
        if (win) exp_drdata = rd;
        else     exp_irdata = rd;
        last_owner = win;

        @(negedge clk);
        mem_finish = 1'b0;
        check("resp.acks", {i_ack, d_ack}, win ? 2'b01 : 2'b10);
        check("resp.i_rdata", i_rdata, exp_irdata);
        check("resp.d_rdata", d_rdata, exp_drdata);
        check("resp.timeout_err", timeout_err, exp_terr);
        check("resp.busy", busy, 1);
        if (spur) begin
            mem_finish    = 1'b1;
            mem_read_data = DATA_W'($urandom);
        end
        if (win) pd_pend = 1'b0;
        else     pi_pend = 1'b0;
        drive_reqs();

        @(negedge clk);
        mem_finish = 1'b0;
        check("idle.busy", busy, 0);
        check("idle.acks", {i_ack, d_ack}, 0);
        check("idle.i_rdata", i_rdata, exp_irdata);
        check("idle.d_rdata", d_rdata, exp_drdata);
        check("idle.mem_addr", mem_addr, ea);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        mem_finish    = 1'b0;
        mem_read_data = '0;
        model_reset();
        drive_reqs();
        repeat (2) @(negedge clk);
        check("rst.mem_sig", mem_sig, 0);
        check("rst.acks", {i_ack, d_ack}, 0);
        check("rst.busy", busy, 0);
        check("rst.grant_id", grant_id, 0);
        check("rst.timeout_err", timeout_err, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.wdata", mem_write_data, 0);
        check("rst.dir", mem_read_or_write, 1);
        check("rst.rdata", {i_rdata, d_rdata}, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int r;
        int fin;
        bit exp_seq[4];

        pi_addr_m  = '0;
        pd_addr_m  = '0;
        pd_wdata_m = '0;
        pd_we_m    = 1'b0;
        do_reset();

        // Instruction read, finish five cycles after mem_sig.
        new_i(ADDR_W'(27'h0000100));
        drive_reqs();
        serve(4, 32'hDEADBEEF, 1'b0, 1'b0);
        check("s1.i_rdata", i_rdata, 32'hDEADBEEF);

        // Data write.
        new_d(1'b1, ADDR_W'(27'h0000200), 32'h12345678);
        drive_reqs();
        serve(2, 32'hA5A5A5A5, 1'b0, 1'b0);

        // Tie after reset alternates D, I, D, I.
        do_reset();
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 4; t++) begin
            if (!pi_pend) new_i(ADDR_W'($urandom));
            if (!pd_pend) new_d(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
            drive_reqs();
            serve(1, DATA_W'($urandom), 1'b0, 1'b0);
            check("tie.grant_seq", seen_grant, exp_seq[t]);
        end
        pi_pend = 1'b0;
        pd_pend = 1'b0;

        // Watchdog abort, then a normal transaction afterwards.
        new_i(ADDR_W'(27'h0000300));
        drive_reqs();
        serve(-1, '0, 1'b0, 1'b0);
        check("to.i_rdata", i_rdata, 0);
        new_d(1'b0, ADDR_W'(27'h0000304), '0);
        drive_reqs();
        serve(3, 32'hCAFEF00D, 1'b0, 1'b0);
        check("to.d_rdata", d_rdata, 32'hCAFEF00D);

        // Spurious finishes in IDLE, ISSUE and RESP with a dropped request.
        new_d(1'b0, ADDR_W'(27'h0000400), '0);
        drive_reqs();
        serve(5, 32'h0BADCAFE, 1'b1, 1'b1);

        // Reset in WAIT, late finish ignored, next request launches at n+1.
        new_i(ADDR_W'(27'h0000500));
        drive_reqs();
        @(negedge clk);
        check("rw.issue", mem_sig, 1);
        pi_pend = 1'b0;
        drive_reqs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw.busy_rst", busy, 0);
        @(negedge clk);
        mem_finish    = 1'b1;
        mem_read_data = 32'h11111111;
        @(negedge clk);
        mem_finish = 1'b0;
        check("rw.no_ack", {i_ack, d_ack}, 0);
        check("rw.busy", busy, 0);
        @(negedge clk);
        check("rw.no_ack2", {i_ack, d_ack}, 0);
        check("rw.i_rdata", i_rdata, 0);
        model_reset();
        new_i(ADDR_W'(27'h0000600));
        drive_reqs();
        serve(0, 32'h22222222, 1'b0, 1'b0);

        // Randomized traffic.
        repeat (150) begin
            if (!pi_pend && $urandom_range(0, 2) != 0) new_i(ADDR_W'($urandom));
            if (!pd_pend && $urandom_range(0, 2) != 0)
                new_d(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
            if (!pi_pend && !pd_pend) new_i(ADDR_W'($urandom));
            drive_reqs();
            r   = int'($urandom_range(0, 9));
            fin = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 5));
            serve(fin, DATA_W'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
